ps2_key_decoder: RTL and testbench

Converts the byte stream from the PS/2 receiver into 1-clock key-press pulses for the game controller. It consumes PS/2 scan code set 2 bytes and tracks the E0 (extended) and F0 (break) prefixes. It suppresses typematic auto-repeat so each physical key press yields exactly one pulse. It sits between the PS/2 serial receiver (upstream) and the game state/direction controller (downstream).

---
 rtl/ps2_codes_pkg.sv | 86 ++++++++
 rtl/ps2_key_decoder.sv | 119 +++++++++++
 tb/tb_ps2_key_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 scan-code set 2 constants, decode-state encoding and key_held
// bit indices for the key decoder.
//   key_index   : scan code + extended flag -> key_held bit index (KEY_NONE if unmapped)
//   pulse_index : key_held bit index -> press-pulse index (arrows alias to W/S/A/D)
package ps2_codes_pkg;

   // Scan codes, set 2
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   // Decode state: bit 0 = E0 seen, bit 1 = F0 seen
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_EXT     = 2'b01,
      ST_BRK     = 2'b10,
      ST_EXT_BRK = 2'b11
   } dec_state_t;

   // key_held bit indices
   localparam int unsigned KEY_W     = 0;
   localparam int unsigned KEY_A     = 1;
   localparam int unsigned KEY_S     = 2;
   localparam int unsigned KEY_D     = 3;
   localparam int unsigned KEY_SPACE = 4;
   localparam int unsigned KEY_R     = 5;
   localparam int unsigned KEY_UP    = 6;
   localparam int unsigned KEY_DOWN  = 7;
   localparam int unsigned KEY_LEFT  = 8;
   localparam int unsigned KEY_RIGHT = 9;
   localparam int unsigned NUM_KEYS  = 10;

   // Press-pulse vector order {r,space,d,s,a,w} matches the first six key bits
   localparam int unsigned NUM_PULSES = 6;

   localparam logic [3:0] KEY_NONE = 4'hF;

   // Map a completed scan code to its key_held bit
   function automatic logic [3:0] key_index(input logic [7:0] sc, input logic ext);
      logic [3:0] idx;
      idx = KEY_NONE;
      if (ext) begin
         case (sc)
            SC_UP:    idx = 4'(KEY_UP);
            SC_DOWN:  idx = 4'(KEY_DOWN);
            SC_LEFT:  idx = 4'(KEY_LEFT);
            SC_RIGHT: idx = 4'(KEY_RIGHT);
            default:  idx = KEY_NONE;
         endcase
      end else begin
         case (sc)
            SC_W:     idx = 4'(KEY_W);
            SC_A:     idx = 4'(KEY_A);
            SC_S:     idx = 4'(KEY_S);
            SC_D:     idx = 4'(KEY_D);
            SC_SPACE: idx = 4'(KEY_SPACE);
            SC_R:     idx = 4'(KEY_R);
            default:  idx = KEY_NONE;
         endcase
      end
      return idx;
   endfunction

   // Arrow keys fold onto the W/S/A/D pulses; other keys pulse their own bit
   function automatic logic [2:0] pulse_index(input logic [3:0] key);
      logic [2:0] p;
      case (key)
         4'(KEY_UP):    p = 3'(KEY_W);
         4'(KEY_DOWN):  p = 3'(KEY_S);
         4'(KEY_LEFT):  p = 3'(KEY_A);
         4'(KEY_RIGHT): p = 3'(KEY_D);
         default:       p = key[2:0];
      endcase
      return p;
   endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: tracks E0/F0 prefixes, keeps per-key held
// state and emits one registered 1-clock pulse per physical key press
// (typematic repeats suppressed).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   code, code_valid  received byte and its 1-clock strobe
//   frame_err         receiver dropped a byte; resync and forget held keys
//   *_press           1-clock press pulses (arrows alias to w/s/a/d)
//   key_held[9:0]     {right,left,down,up,r,space,d,s,a,w}
module ps2_key_decoder
   import ps2_codes_pkg::*;
#(
   parameter int unsigned PREFIX_TIMEOUT = 100000,
   parameter bit          ARROWS_EN      = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          code,
   input  logic                code_valid,
   input  logic                frame_err,
   output logic                w_press,
   output logic                a_press,
   output logic                s_press,
   output logic                d_press,
   output logic                space_press,
   output logic                r_press,
   output logic [NUM_KEYS-1:0] key_held
);

   localparam int unsigned     CNT_W      = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(PREFIX_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   dec_state_t              state;
   logic [CNT_W-1:0]        cnt;
   logic [NUM_PULSES-1:0]   pulse;

   logic       is_ext;
   logic       is_brk;
   logic       ext_ctx;
   logic       brk_ctx;
   logic       key_ok;
   logic [3:0] key_idx;
   logic [2:0] pulse_idx;

   // Classify the incoming byte in the context of the prefixes already seen
   always_comb begin
      is_ext    = (code == SC_EXT);
      is_brk    = (code == SC_BRK);
      ext_ctx   = (state == ST_EXT) || (state == ST_EXT_BRK);
      brk_ctx   = (state == ST_BRK) || (state == ST_EXT_BRK);
      key_idx   = key_index(code, ext_ctx);
      pulse_idx = pulse_index(key_idx);
      key_ok    = (key_idx != KEY_NONE) && (!ext_ctx || ARROWS_EN);
   end

   // Decode FSM, prefix timeout, held keys and press pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         key_held <= '0;
         pulse    <= '0;
      end else begin
         pulse <= '0;
         if (frame_err) begin
            // A lost byte may have been a break: forget every held key
            state    <= ST_IDLE;
            cnt      <= '0;
            key_held <= '0;
         end else if (code_valid) begin
            cnt <= '0;
            case (state)
               ST_IDLE: begin
                  if (is_ext)      state <= ST_EXT;
                  else if (is_brk) state <= ST_BRK;
               end
               ST_EXT: begin
                  if (is_brk)       state <= ST_EXT_BRK;
                  else if (!is_ext) state <= ST_IDLE;
               end
               ST_BRK: begin
                  if (is_ext)       state <= ST_EXT_BRK;
                  else if (!is_brk) state <= ST_IDLE;
               end
               ST_EXT_BRK: begin
                  if (!is_ext && !is_brk) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
            if (!is_ext && !is_brk && key_ok) begin
               if (brk_ctx) begin
                  key_held[key_idx] <= 1'b0;
               end else if (!key_held[key_idx]) begin
                  // First make only; typematic repeats find the bit already set
                  key_held[key_idx] <= 1'b1;
                  pulse[pulse_idx]  <= 1'b1;
               end
            end
         end else if (state != ST_IDLE) begin
            // Abandon a dangling prefix once the follow-up byte is overdue
            if (cnt == CNT_EXPIRE) begin
               state <= ST_IDLE;
               cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign w_press     = pulse[KEY_W];
   assign a_press     = pulse[KEY_A];
   assign s_press     = pulse[KEY_S];
   assign d_press     = pulse[KEY_D];
   assign space_press = pulse[KEY_SPACE];
   assign r_press     = pulse[KEY_R];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (arrows enabled / disabled) share
// one stimulus stream and are compared every cycle against a prefix-flag
// reference model, plus a directed vector table and hand-written corner cases.
module tb_ps2_key_decoder;

   localparam int unsigned PT = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] code;
   logic       cv;
   logic       fe;
   logic [5:0] p1, p0;
   logic [9:0] h1, h0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   ps2_key_decoder #(.PREFIX_TIMEOUT(PT), .ARROWS_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .code(code), .code_valid(cv), .frame_err(fe),
      .w_press(p1[0]), .a_press(p1[1]), .s_press(p1[2]), .d_press(p1[3]),
      .space_press(p1[4]), .r_press(p1[5]), .key_held(h1)
   );

   ps2_key_decoder #(.PREFIX_TIMEOUT(PT), .ARROWS_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .code(code), .code_valid(cv), .frame_err(fe),
      .w_press(p0[0]), .a_press(p0[1]), .s_press(p0[2]), .d_press(p0[3]),
      .space_press(p0[4]), .r_press(p0[5]), .key_held(h0)
   );

   // Reference model: index 1 = arrows enabled, index 0 = arrows disabled
   bit         m_ext  [2];
   bit         m_brk  [2];
   int         m_last [2];
   logic [9:0] m_held [2];
   logic [5:0] m_pulse[2];

   // Key codes by key_held bit; pulse bit each key drives
   logic [7:0] kc [10] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h2D,
                           8'h75, 8'h72, 8'h6B, 8'h74};
   int         pm [10] = '{0, 1, 2, 3, 4, 5, 0, 2, 1, 3};

   function automatic int lookup(input logic [7:0] c, input bit ext);
      for (int i = 0; i < 10; i++)
         if ((i >= 6) == ext && kc[i] == c) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < 2; a++) begin
         m_ext[a] = 0; m_brk[a] = 0; m_last[a] = 0;
         m_held[a] = '0; m_pulse[a] = '0;
      end
   endtask

   task automatic model_step(input bit cvi, input bit fei, input logic [7:0] c);
      int k;
      for (int a = 0; a < 2; a++) begin
         m_pulse[a] = '0;
         if (fei) begin
            m_ext[a] = 0; m_brk[a] = 0; m_held[a] = '0;
         end else if (cvi) begin
            // A prefix older than PT cycles has been abandoned
            if ((m_ext[a] || m_brk[a]) && (cyc - m_last[a] > int'(PT))) begin
               m_ext[a] = 0; m_brk[a] = 0;
            end
            if (c == 8'hE0) begin
               m_ext[a] = 1; m_last[a] = cyc;
            end else if (c == 8'hF0) begin
               m_brk[a] = 1; m_last[a] = cyc;
            end else begin
               k = lookup(c, m_ext[a]);
               if (k >= 0 && !(m_ext[a] && a == 0)) begin
                  if (m_brk[a]) m_held[a][k] = 1'b0;
                  else if (!m_held[a][k]) begin
                     m_held[a][k] = 1'b1;
                     m_pulse[a][pm[k]] = 1'b1;
                  end
               end
               m_ext[a] = 0; m_brk[a] = 0;
            end
         end
      end
   endtask

   // One clock with the given inputs; outputs checked #1 after the edge
   task automatic step(input bit cvi, input bit fei, input logic [7:0] c);
      @(negedge clk);
      cv = cvi; fe = fei; code = c;
      @(posedge clk);
      model_step(cvi, fei, c);
      cyc++;
      #1;
      chk("model_pulse_arrows_on",  16'(p1), 16'(m_pulse[1]));
      chk("model_held_arrows_on",   16'(h1), 16'(m_held[1]));
      chk("model_pulse_arrows_off", 16'(p0), 16'(m_pulse[0]));
      chk("model_held_arrows_off",  16'(h0), 16'(m_held[0]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      cv = 0; fe = 0; code = 8'h00;
      rst = 1'b1;
      #1;
      chk("reset_async_outputs", 16'({p1, p0}), 16'h0);
      chk("reset_async_held1", 16'(h1), 16'h0);
      chk("reset_async_held0", 16'(h0), 16'h0);
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit         cv;
      bit         fe;
      logic [7:0] code;
      logic [5:0] pulse;
      logic [9:0] held;
   } vec_t;

   vec_t vt[26];

   initial begin
      logic [7:0] c;
      int         r;

      vt[0]  = '{1'b1, 1'b0, 8'h1D, 6'h01, 10'h001};
      vt[1]  = '{1'b1, 1'b0, 8'h1D, 6'h00, 10'h001};
      vt[2]  = '{1'b1, 1'b0, 8'h1D, 6'h00, 10'h001};
      vt[3]  = '{1'b1, 1'b0, 8'hF0, 6'h00, 10'h001};
      vt[4]  = '{1'b1, 1'b0, 8'h1D, 6'h00, 10'h000};
      vt[5]  = '{1'b1, 1'b0, 8'h1D, 6'h01, 10'h001};
      vt[6]  = '{1'b1, 1'b0, 8'hE0, 6'h00, 10'h001};
      vt[7]  = '{1'b1, 1'b0, 8'h75, 6'h01, 10'h041};
      vt[8]  = '{1'b1, 1'b0, 8'hE0, 6'h00, 10'h041};
      vt[9]  = '{1'b1, 1'b0, 8'hF0, 6'h00, 10'h041};
      vt[10] = '{1'b1, 1'b0, 8'h75, 6'h00, 10'h001};
      vt[11] = '{1'b1, 1'b0, 8'hF0, 6'h00, 10'h001};
      vt[12] = '{1'b1, 1'b0, 8'h29, 6'h00, 10'h001};
      vt[13] = '{1'b1, 1'b0, 8'h2D, 6'h20, 10'h021};
      vt[14] = '{1'b0, 1'b1, 8'h00, 6'h00, 10'h000};
      vt[15] = '{1'b1, 1'b0, 8'h2D, 6'h20, 10'h020};
      vt[16] = '{1'b1, 1'b1, 8'h29, 6'h00, 10'h000};
      vt[17] = '{1'b1, 1'b0, 8'h29, 6'h10, 10'h010};
      vt[18] = '{1'b0, 1'b0, 8'h00, 6'h00, 10'h010};
      vt[19] = '{1'b1, 1'b0, 8'hE0, 6'h00, 10'h010};
      vt[20] = '{1'b1, 1'b0, 8'h72, 6'h04, 10'h090};
      vt[21] = '{1'b1, 1'b0, 8'h1B, 6'h04, 10'h094};
      vt[22] = '{1'b1, 1'b0, 8'hF0, 6'h00, 10'h094};
      vt[23] = '{1'b1, 1'b0, 8'hE0, 6'h00, 10'h094};
      vt[24] = '{1'b1, 1'b0, 8'h72, 6'h00, 10'h014};
      vt[25] = '{1'b1, 1'b0, 8'h33, 6'h00, 10'h014};

      rst = 1'b1; cv = 0; fe = 0; code = 8'h00;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset_pulses", 16'({p1, p0}), 16'h0);
      chk("reset_held",   16'({h1[5:0], h0}), 16'h0);
      rst = 1'b0;

      // Directed vector table (arrows-enabled instance)
      for (int i = 0; i < 26; i++) begin
         step(vt[i].cv, vt[i].fe, vt[i].code);
         chk($sformatf("vec%0d_pulse", i), 16'(p1), 16'(vt[i].pulse));
         chk($sformatf("vec%0d_held", i),  16'(h1), 16'(vt[i].held));
      end
      chk("arrows_off_held_hi", 16'(h0[9:6]), 16'h0);

      // Prefix timeout: byte in the expiry cycle still completes the prefix
      step(0, 1, 8'h00);
      step(1, 0, 8'h29);
      chk("space_make", 16'(p1), 16'h10);
      step(1, 0, 8'hF0);
      repeat (PT - 1) step(0, 0, 8'h00);
      step(1, 0, 8'h29);
      chk("expiry_cycle_break_pulse", 16'(p1), 16'h00);
      chk("expiry_cycle_break_held",  16'(h1[4]), 16'h0);
      step(1, 0, 8'h29);
      chk("remake_after_break", 16'(p1), 16'h10);
      step(1, 0, 8'hF0);
      step(1, 0, 8'h29);
      chk("break_clears", 16'(h1[4]), 16'h0);
      // Past the timeout the stale E0 F0 is dropped and 29 is a make
      step(1, 0, 8'hE0);
      step(1, 0, 8'hF0);
      repeat (PT) step(0, 0, 8'h00);
      step(1, 0, 8'h29);
      chk("timeout_then_make", 16'(p1), 16'h10);
      chk("timeout_then_make_off", 16'(p0), 16'h10);
      step(1, 0, 8'h29);
      chk("timeout_idle_repeat", 16'(p1), 16'h00);

      // Reset mid-sequence aborts the prefix
      step(1, 0, 8'hE0);
      do_reset();
      step(1, 0, 8'h29);
      chk("post_reset_space", 16'(p1), 16'h10);
      chk("post_reset_held",  16'(h1), 16'h010);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            step($urandom_range(0, 1), 1, kc[$urandom_range(0, 9)]);
         end else if (r < 20) begin
            repeat ($urandom_range(1, PT + 4)) step(0, 0, 8'h00);
         end else begin
            r = $urandom_range(0, 99);
            if (r < 55)      c = kc[$urandom_range(0, 9)];
            else if (r < 72) c = 8'hE0;
            else if (r < 90) c = 8'hF0;
            else if (r < 95) c = 8'h33;
            else             c = 8'($urandom);
            step(1, 0, c);
         end
      end

      @(negedge clk);
      cv = 0; fe = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
